// File: rtl/sw_score_packer.sv
// -----------------------------------------------------------------------------
// sw_score_packer
//
// Host-bound end of the Smith-Waterman score path. Takes one score per
// handshake from the PE-array readout, packs two scores per FIFO word (first
// score in the low half) and writes the words into the 32-bit read FIFO that
// feeds /dev/xillybus_read_32. The last score of a row flushes a zero-padded
// half word. Once that final word is written, end-of-row status is raised.
//
// Ports:
//   clk            system clock (bus_clk)
//   rst_n          asynchronous active-low reset
//   score_i        score from the PE readout
//   score_valid_i  score_i is valid
//   score_last_i   score_i is the last score of the current row/packet
//   score_ready_o  block can accept a score this cycle
//   fifo_din_o     packed word to the read FIFO
//   fifo_wren_o    FIFO write enable
//   fifo_full_i    read FIFO full
//   words_o        words written in the current packet (saturating)
//   max_score_o    running unsigned maximum score in the current packet
//   done_o         one-cycle pulse after the final word of a packet is written
//   eof_o          level, packet complete (feeds the read EOF logic)
// -----------------------------------------------------------------------------
module sw_score_packer #(
   parameter int SCORE_W = 16,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SCORE_W-1:0]     score_i,
   input  logic                   score_valid_i,
   input  logic                   score_last_i,
   output logic                   score_ready_o,
   output logic [2*SCORE_W-1:0]   fifo_din_o,
   output logic                   fifo_wren_o,
   input  logic                   fifo_full_i,
   output logic [CNT_W-1:0]       words_o,
   output logic [SCORE_W-1:0]     max_score_o,
   output logic                   done_o,
   output logic                   eof_o
);

   localparam int WORD_W = 2 * SCORE_W;

   typedef enum logic {ST_EMPTY, ST_HALF} state_t;

   state_t              r_state;
   logic [SCORE_W-1:0]  r_low;
   logic [WORD_W-1:0]   r_pend_word;
   logic                r_pend_valid;
   logic                r_pend_last;
   logic [CNT_W-1:0]    r_words;
   logic [SCORE_W-1:0]  r_max;
   logic                r_done;
   logic                r_eof;

   logic                w_acc;
   logic                w_wr;
   logic                w_complete;
   logic                w_new_packet;
   logic [CNT_W-1:0]    w_words_inc;
   logic [SCORE_W-1:0]  w_max_next;

   // A pending word that drains this cycle frees the slot for a new accept.
   assign score_ready_o = !r_pend_valid || !fifo_full_i;
   assign fifo_wren_o   = r_pend_valid && !fifo_full_i;
   assign fifo_din_o    = r_pend_word;
   assign words_o       = r_words;
   assign max_score_o   = r_max;
   assign done_o        = r_done;
   assign eof_o         = r_eof;

   assign w_acc        = score_valid_i && score_ready_o;
   assign w_wr         = fifo_wren_o;
   // A word is completed by the second score of a pair, or by a lone last score.
   assign w_complete   = w_acc && ((r_state == ST_HALF) || score_last_i);
   // First accept after end-of-row starts a fresh packet.
   assign w_new_packet = w_acc && r_eof;
   assign w_words_inc  = (r_words == {CNT_W{1'b1}}) ? r_words : r_words + 1'b1;
   assign w_max_next   = (w_new_packet || (score_i > r_max)) ? score_i : r_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_EMPTY;
         r_low        <= '0;
         r_pend_word  <= '0;
         r_pend_valid <= 1'b0;
         r_pend_last  <= 1'b0;
         r_words      <= '0;
         r_max        <= '0;
         r_done       <= 1'b0;
         r_eof        <= 1'b0;
      end else begin
         if (w_acc) begin
            case (r_state)
               ST_EMPTY: begin
                  if (score_last_i) begin
                     r_pend_word <= {{SCORE_W{1'b0}}, score_i};
                  end else begin
                     r_low   <= score_i;
                     r_state <= ST_HALF;
                  end
               end
               ST_HALF: begin
                  r_pend_word <= {score_i, r_low};
                  r_state     <= ST_EMPTY;
               end
               default: r_state <= ST_EMPTY;
            endcase
         end

         // A completing accept reloads the slot even while it is being written.
         if (w_complete) begin
            r_pend_valid <= 1'b1;
            r_pend_last  <= score_last_i;
         end else if (w_wr) begin
            r_pend_valid <= 1'b0;
         end

         r_done <= w_wr && r_pend_last;

         if (w_wr && r_pend_last) begin
            r_eof <= 1'b1;
         end else if (w_new_packet) begin
            r_eof <= 1'b0;
         end

         if (w_new_packet) begin
            r_words <= {{(CNT_W-1){1'b0}}, w_wr};
         end else if (w_wr) begin
            r_words <= w_words_inc;
         end

         if (w_acc) begin
            r_max <= w_max_next;
         end
      end
   end

endmodule
